key_press_decoder: RTL
======================

// Module: key_press_decoder
// PURPOSE
//  Consumes the clean, debounced key level and classifies each press into discrete events:
//  short press, long press and optional auto-repeat. Sits between the key debouncer and the
//  alarm-clock control FSM. Events are single-cycle pulses in the clk domain.
// PARAMETERS
//  TICK_DIV      1000000  clk cycles per hold-timing tick (100 MHz -> 100 Hz, 10 ms)
//  TICK_W        20       width of prescaler counter; must satisfy 2**TICK_W >= TICK_DIV
//  LONG_TICKS    100      ticks of continuous hold that qualify a long press (1 s)
//  REPEAT_TICKS  20       ticks between auto-repeat pulses after long press (200 ms)
//  CNT_W         8        hold counter width; 2**CNT_W > max(LONG_TICKS, REPEAT_TICKS)
// PORTS
//  clk           in   1      system clock, single domain
//  rst_n         in   1      asynchronous active-low reset
//  key_in        in   1      debounced key level, 1 = pressed
//  short_press   out  1      1-cycle pulse: released before long threshold
//  long_press    out  1      1-cycle pulse: hold reached LONG_TICKS
//  repeat_pulse  out  1      1-cycle pulse per REPEAT_TICKS while held after long press
//  key_held      out  1      level: 1 while in PRESS or LONG
// BEHAVIOUR
//  - Reset: state IDLE, hold cnt 0, prescaler 0, all outputs 0. Reset mid-hold aborts
//    immediately, with no event emitted.
//  - Tick: free-running prescaler; 1-cycle pulse when count == TICK_DIV-1, then wraps to 0.
//    Hold time is quantised to ticks, so long_press fires between (LONG_TICKS-1)*TICK_DIV
//    and LONG_TICKS*TICK_DIV cycles after the press.
//  - All outputs are registered. A pulse is high in the cycle after the triggering condition
//    is sampled, for exactly one cycle.
//  - FSM:
//    IDLE : key_in=1 -> PRESS, cnt<=0.
//    PRESS: key_in=0 -> IDLE, short_press.
//           else on tick: if cnt==LONG_TICKS-1 -> LONG, cnt<=0, long_press; else cnt++.
//    LONG : key_in=0 -> IDLE, no event.
//           else on tick: if cnt==REPEAT_TICKS-1 -> repeat_pulse, cnt<=0; else cnt++.
//  - Simultaneous release and threshold tick: release wins. In PRESS this emits short_press
//    and no long_press. In LONG this emits no repeat_pulse.
//  - key_in high when reset deasserts: first cycle goes IDLE -> PRESS and timing starts then.
//  - Counter never exceeds its threshold. At most one output pulse per cycle.
//  - Illegal state encoding -> IDLE.
// CONFIGURATION
//  - KEY_REPEAT_EN defined: the LONG-state repeat behaviour is as described above.
//  - KEY_REPEAT_EN undefined: repeat_pulse is tied to 0, the counter holds in LONG, and
//    LONG exits only on release.
// STRUCTURE
//  - Package key_pkg: FSM state encodings (KEY_IDLE, KEY_PRESS, KEY_LONG) and default
//    timing constants (100 Hz tick, 1 s long press, 200 ms repeat).
//  - Sub-module key_tick_prescaler (TICK_DIV, TICK_W): clk, rst_n -> tick.
//  - FSM, hold counter and output registers live in the top module.
// TESTING  (TICK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=2)
//  - Reset asserted with key_in=1 -> all outputs 0. Release reset -> key_held=1 one cycle later.
//  - Hold 2 ticks, then release -> exactly one short_press; long_press=0; key_held drops
//    in the same cycle.
//  - Hold 7 ticks -> long_press once, at the 5th tick; release -> no short_press.
//  - KEY_REPEAT_EN, hold 11 ticks -> long_press at tick 5 and repeat_pulse at ticks 7, 9, 11.
//    Without the macro -> repeat_pulse stays 0.
//  - Release in the same cycle as the 5th tick -> short_press=1, long_press never asserts.
//  - rst_n pulsed low at tick 3 of a hold, key_in kept 1 -> no event. long_press follows only
//    after 5 fresh ticks.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key press decoder: FSM state encodings and default timing
// constants (100 Hz hold tick at 100 MHz, 1 s long press, 200 ms auto-repeat).
package key_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE  = 2'b00,
        KEY_PRESS = 2'b01,
        KEY_LONG  = 2'b10
    } key_state_e;

    localparam int KEY_TICK_DIV     = 1000000;
    localparam int KEY_TICK_W       = 20;
    localparam int KEY_LONG_TICKS   = 100;
    localparam int KEY_REPEAT_TICKS = 20;
    localparam int KEY_CNT_W        = 8;

endpackage

// File: rtl/key_tick_prescaler.sv
// Free-running prescaler: tick is high for one clk cycle every TICK_DIV cycles,
// while the count sits at TICK_DIV-1.
module key_tick_prescaler
    import key_pkg::*;
#(
    parameter int TICK_DIV = KEY_TICK_DIV,
    parameter int TICK_W   = KEY_TICK_W
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/key_press_decoder.sv
// Classifies debounced key presses into short/long/auto-repeat single-cycle pulses.
// Auto-repeat in the LONG state is enabled by defining KEY_REPEAT_EN.
module key_press_decoder
    import key_pkg::*;
#(
    parameter int TICK_DIV     = KEY_TICK_DIV,
    parameter int TICK_W       = KEY_TICK_W,
    parameter int LONG_TICKS   = KEY_LONG_TICKS,
    parameter int REPEAT_TICKS = KEY_REPEAT_TICKS,
    parameter int CNT_W        = KEY_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic key_held
);

`ifdef KEY_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    key_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             short_nxt, long_nxt, repeat_nxt;
    logic             tick;

    key_tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= KEY_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        case (state)
            KEY_IDLE: begin
                if (key_in) begin
                    state_nxt = KEY_PRESS;
                    cnt_nxt   = '0;
                end
            end
            KEY_PRESS: begin
                // Release is checked before the tick so it wins a same-cycle threshold.
                if (!key_in) begin
                    state_nxt = KEY_IDLE;
                    cnt_nxt   = '0;
                    short_nxt = 1'b1;
                end else if (tick) begin
                    if (cnt == LONG_LAST) begin
                        state_nxt = KEY_LONG;
                        cnt_nxt   = '0;
                        long_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            KEY_LONG: begin
                if (!key_in) begin
                    state_nxt = KEY_IDLE;
                    cnt_nxt   = '0;
                end else if (REPEAT_EN && tick) begin
                    if (cnt == REPEAT_LAST) begin
                        cnt_nxt    = '0;
                        repeat_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = KEY_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            key_held     <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            repeat_pulse <= repeat_nxt;
            key_held     <= (state_nxt != KEY_IDLE);
        end
    end

endmodule
